iob_cache_be_lat_mem: RTL

//  Back-end memory model on the cache's native IOb back-end port (be_*), downstream of iob_cache_iob.

---
 rtl/iob_cache_be_lat_mem_pkg.sv | 26 ++
 rtl/iob_cache_be_lat_mem_if.sv | 36 +++
 rtl/iob_cache_be_lat_mem_lfsr.sv | 35 +++
 rtl/iob_cache_be_lat_mem.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/iob_cache_be_lat_mem_pkg.sv
// ----------------------------------------------------------------------------
// iob_cache_be_lat_mem_pkg
//   Shared definitions for the latency-programmable back-end memory model:
//   the FSM state encoding and the LFSR seed/taps that are used when
//   random latency is enabled (macro IOB_CACHE_BE_MEM_RANDLAT_EN).
//   No ports: imported by the interface users, the top and the LFSR.
// ----------------------------------------------------------------------------
package iob_cache_be_lat_mem_pkg;

  // IDLE evaluates a fresh request; WAIT burns the remaining wait states.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int          LFSR_W    = 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as a mask over bits [15],[13],[12],[10].
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Fibonacci feedback: XOR of all tapped bits, shifted in at bit 0.
  function automatic logic lfsr_feedback(input logic [15:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/iob_cache_be_lat_mem_if.sv
// ----------------------------------------------------------------------------
// iob_cache_be_lat_mem_if
//   IOb back-end request/response bundle between the cache back-end (master)
//   and the memory model (slave).
//   valid  : request valid                 (master -> slave)
//   addr   : byte address                  (master -> slave)
//   wdata  : write data                    (master -> slave)
//   wstrb  : byte strobes, 0 means read    (master -> slave)
//   rdata  : read data, qualified by rvalid(slave -> master)
//   rvalid : read data valid, 1-cycle pulse(slave -> master)
//   ready  : request accepted this cycle   (slave -> master)
// ----------------------------------------------------------------------------
interface iob_cache_be_lat_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 24
);
  localparam int NBYTES = DATA_W / 8;

  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [NBYTES-1:0] wstrb;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              ready;

  modport master (
    output valid, addr, wdata, wstrb,
    input  rdata, rvalid, ready
  );

  modport slave (
    input  valid, addr, wdata, wstrb,
    output rdata, rvalid, ready
  );
endinterface

// File: rtl/iob_cache_be_lat_mem_lfsr.sv
// ----------------------------------------------------------------------------
// iob_cache_be_lat_mem_lfsr
//   16-bit Fibonacci LFSR (taps 16,14,13,11) used as the source of random
//   wait-state counts. Reloads SEED on reset and advances once per enabled
//   cycle, so the sequence is repeatable after every reset.
//   Only instantiated when IOB_CACHE_BE_MEM_RANDLAT_EN is defined.
//   Ports:
//     clk_i   : clock
//     rst_n_i : synchronous active-low reset
//     cke_i   : clock enable, 0 holds the register
//     lfsr_o  : current LFSR state
//   WIDTH must stay 16 for the tap set in the package.
// ----------------------------------------------------------------------------
module iob_cache_be_lat_mem_lfsr
  import iob_cache_be_lat_mem_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = LFSR_SEED
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             cke_i,
  output logic [WIDTH-1:0] lfsr_o
);

  // Shift left, feeding the tap XOR into bit 0; reset has priority over cke.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      lfsr_o <= SEED;
    end else if (cke_i) begin
      lfsr_o <= {lfsr_o[WIDTH-2:0], lfsr_feedback(lfsr_o)};
    end
  end

endmodule

// File: rtl/iob_cache_be_lat_mem.sv
// ----------------------------------------------------------------------------
// iob_cache_be_lat_mem
//   Back-end memory model for the cache's IOb back-end port. A byte-enabled
//   word memory that inserts a programmable number of wait states before
//   asserting ready, so cache miss/stall paths get exercised.
//   Simulation / FPGA bench use only.
//   Ports:
//     clk_i   : clock
//     rst_n_i : synchronous active-low reset (wins over cke_i)
//     cke_i   : clock enable; 0 freezes all state and forces ready low
//     be      : slave side of iob_cache_be_lat_mem_if (valid/addr/wdata/
//               wstrb in, rdata/rvalid/ready out)
//   Configuration:
//     IOB_CACHE_BE_MEM_RANDLAT_EN defined -> wait states come from an LFSR
//     sampled in IDLE and LAT is ignored; undefined -> fixed LAT wait states.
//   Addresses alias: only the word-index bits select a memory word.
//   ADDR_W must be larger than MEM_ADDR_W + log2(DATA_W/8).
// ----------------------------------------------------------------------------
module iob_cache_be_lat_mem
  import iob_cache_be_lat_mem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 24,
  parameter int MEM_ADDR_W = 12,
  parameter int LAT_W      = 4,
  parameter int LAT        = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   cke_i,
  iob_cache_be_lat_mem_if.slave  be
);

  localparam int NBYTES   = DATA_W / 8;
  localparam int NBYTES_W = $clog2(NBYTES);
  localparam int DEPTH    = 2 ** MEM_ADDR_W;

  state_t                state;
  state_t                state_nxt;
  logic [LAT_W-1:0]      cnt;
  logic [LAT_W-1:0]      cnt_nxt;
  logic [LAT_W-1:0]      cur_lat;
  logic                  ready;
  logic                  is_read;
  logic                  is_write;
  logic [MEM_ADDR_W-1:0] idx;
  logic [DATA_W-1:0]     rdata_q;
  logic                  rvalid_q;
  logic [DATA_W-1:0]     mem [DEPTH];

  // Bits outside the word index are deliberately ignored (aliasing).
  logic unused_addr;
  assign unused_addr = ^{be.addr[ADDR_W-1:MEM_ADDR_W+NBYTES_W],
                         be.addr[NBYTES_W-1:0]};

  assign idx       = be.addr[MEM_ADDR_W+NBYTES_W-1:NBYTES_W];
  assign is_write  = ready & (|be.wstrb);
  assign is_read   = ready & ~(|be.wstrb);
  assign be.ready  = ready;
  assign be.rdata  = rdata_q;
  assign be.rvalid = rvalid_q;

`ifdef IOB_CACHE_BE_MEM_RANDLAT_EN
  logic [LFSR_W-1:0] lfsr;
  logic              unused_lfsr;
  localparam int     unused_lat = LAT;

  iob_cache_be_lat_mem_lfsr #(
    .WIDTH (LFSR_W),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .cke_i   (cke_i),
    .lfsr_o  (lfsr)
  );

  // The low LFSR bits are the wait-state count; it is only consumed in IDLE,
  // so a request's latency is fixed at the moment it is first seen.
  assign cur_lat     = lfsr[LAT_W-1:0];
  assign unused_lfsr = ^lfsr[LFSR_W-1:LAT_W];
`else
  assign cur_lat = LAT_W'(LAT);
`endif

  // State and wait counter; reset has priority, cke_i low holds everything.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (cke_i) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and ready. IDLE spends one wait state deciding to wait, so the
  // counter is loaded with cur_lat-1 and WAIT accepts when it reaches zero.
  // Losing valid while waiting aborts the request without touching memory.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 1'b0;
    if (cke_i && rst_n_i) begin
      case (state)
        IDLE: begin
          if (be.valid) begin
            if (cur_lat == '0) begin
              ready = 1'b1;
            end else begin
              cnt_nxt   = cur_lat - LAT_W'(1);
              state_nxt = WAIT;
            end
          end
        end
        WAIT: begin
          if (!be.valid) begin
            state_nxt = IDLE;
          end else if (cnt == '0) begin
            ready     = 1'b1;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt - LAT_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Byte-enabled write at the handshake edge; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (is_write) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (be.wstrb[b]) begin
          mem[idx][b*8 +: 8] <= be.wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read response one edge after the handshake; rdata holds until next read.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (cke_i) begin
      rvalid_q <= is_read;
      if (is_read) begin
        rdata_q <= mem[idx];
      end
    end
  end

endmodule
